// File: rtl/rom_fetch_arbiter.sv
// Shares one SDRAM read port between the 68000 program ROM, the Z80 program ROM and the
// uPD7759 sample ROM, with round-robin arbitration and a one-word cache per requester.
module rom_fetch_arbiter #(
  parameter logic [21:0] M68K_BASE = 22'h000000,
  parameter logic [21:0] Z80_BASE  = 22'h020000,
  parameter logic [21:0] SMP_BASE  = 22'h028000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m68k_rom_cs,
  input  logic [16:0] m68k_a,
  output logic [15:0] m68k_dout,
  output logic        m68k_ok,
  input  logic        z80_rom_cs,
  input  logic [15:0] z80_addr,
  output logic [7:0]  z80_dout,
  output logic        z80_ok,
  input  logic        smp_rd,
  input  logic [16:0] smp_addr,
  output logic [7:0]  smp_dout,
  output logic        smp_ok,
  output logic        sdr_req,
  output logic [21:0] sdr_addr,
  input  logic        sdr_ack,
  input  logic [15:0] sdr_data
);

  // SDRAM handshake: sdr_req rises with sdr_addr and both stay stable until the one-cycle
  // sdr_ack; sdr_req drops on the ack edge, and an ack seen while idle is ignored.
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state;
  logic [1:0]  grant, ptr, gsel, cand;
  logic        found;
  logic [21:0] gsel_addr;

  logic        m68k_cs_q, m68k_pend, m68k_cv;
  logic [16:0] m68k_a_q;
  logic [21:0] m68k_req_addr, m68k_ca;
  logic [15:0] m68k_cd;
  logic        z80_cs_q, z80_pend, z80_cv;
  logic [15:0] z80_a_q;
  logic [21:0] z80_req_addr, z80_ca;
  logic [15:0] z80_cd;
  logic        smp_pend, smp_cv, smp_sel;
  logic [21:0] smp_req_addr, smp_ca;
  logic [15:0] smp_cd;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic pend_of(input logic [1:0] p, input logic [2:0] v);
    case (p)
      2'd0:    return v[0];
      2'd1:    return v[1];
      default: return v[2];
    endcase
  endfunction

  function automatic logic [7:0] pick(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

  wire [21:0] m68k_wa = M68K_BASE + {5'd0, m68k_a};
  wire [21:0] z80_wa  = Z80_BASE + {7'd0, z80_addr[15:1]};
  wire [21:0] smp_wa  = SMP_BASE + {6'd0, smp_addr[16:1]};

  wire m68k_ev = m68k_rom_cs && (!m68k_cs_q || m68k_a != m68k_a_q);
  wire z80_ev  = z80_rom_cs && (!z80_cs_q || z80_addr != z80_a_q);

  wire in_ack   = (state == ST_WAIT) && sdr_ack;
  wire m68k_ack = in_ack && grant == 2'd0;
  wire z80_ack  = in_ack && grant == 2'd1;
  wire smp_ack  = in_ack && grant == 2'd2;

  // A word arriving on this very edge counts as cached for a request made on the same edge.
  wire m68k_fill = m68k_ack && sdr_addr == m68k_wa;
  wire z80_fill  = z80_ack && sdr_addr == z80_wa;
  wire smp_fill  = smp_ack && sdr_addr == smp_wa;
  wire m68k_hit  = m68k_fill || (m68k_cv && m68k_ca == m68k_wa);
  wire z80_hit   = z80_fill || (z80_cv && z80_ca == z80_wa);
  wire smp_hit   = smp_fill || (smp_cv && smp_ca == smp_wa);
  wire [15:0] m68k_hd = m68k_fill ? sdr_data : m68k_cd;
  wire [15:0] z80_hd  = z80_fill ? sdr_data : z80_cd;
  wire [15:0] smp_hd  = smp_fill ? sdr_data : smp_cd;

  always_comb begin
    cand  = ptr;
    gsel  = ptr;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && pend_of(cand, {smp_pend, z80_pend, m68k_pend})) begin
        found = 1'b1;
        gsel  = cand;
      end
      cand = rr_next(cand);
    end
  end

  always_comb begin
    case (gsel)
      2'd0:    gsel_addr = m68k_req_addr;
      2'd1:    gsel_addr = z80_req_addr;
      default: gsel_addr = smp_req_addr;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      grant    <= 2'd0;
      ptr      <= 2'd0;
      sdr_req  <= 1'b0;
      sdr_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: if (found) begin
          grant    <= gsel;
          sdr_addr <= gsel_addr;
          sdr_req  <= 1'b1;
          state    <= ST_WAIT;
        end
        ST_WAIT: if (sdr_ack) begin
          sdr_req <= 1'b0;
          ptr     <= rr_next(grant);
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m68k_cs_q <= 1'b0; m68k_a_q <= '0; m68k_pend <= 1'b0; m68k_req_addr <= '0;
      m68k_cv <= 1'b0; m68k_ca <= '0; m68k_cd <= '0; m68k_ok <= 1'b0; m68k_dout <= '0;
    end else begin
      m68k_cs_q <= m68k_rom_cs;
      m68k_a_q  <= m68k_a;
      if (m68k_ack) begin
        m68k_cv <= 1'b1; m68k_ca <= sdr_addr; m68k_cd <= sdr_data;
      end
      if (m68k_ev) begin
        m68k_ok   <= m68k_hit;
        m68k_pend <= !m68k_hit;
        if (m68k_hit) m68k_dout <= m68k_hd;
        else m68k_req_addr <= m68k_wa;
      end else if (m68k_ack) begin
        if (m68k_req_addr == sdr_addr) m68k_pend <= 1'b0;
        if (m68k_rom_cs && m68k_wa == sdr_addr) begin
          m68k_ok <= 1'b1; m68k_dout <= sdr_data;
        end else if (!m68k_rom_cs) m68k_ok <= 1'b0;
      end else if (!m68k_rom_cs) m68k_ok <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z80_cs_q <= 1'b0; z80_a_q <= '0; z80_pend <= 1'b0; z80_req_addr <= '0;
      z80_cv <= 1'b0; z80_ca <= '0; z80_cd <= '0; z80_ok <= 1'b0; z80_dout <= '0;
    end else begin
      z80_cs_q <= z80_rom_cs;
      z80_a_q  <= z80_addr;
      if (z80_ack) begin
        z80_cv <= 1'b1; z80_ca <= sdr_addr; z80_cd <= sdr_data;
      end
      if (z80_ev) begin
        z80_ok   <= z80_hit;
        z80_pend <= !z80_hit;
        if (z80_hit) z80_dout <= pick(z80_hd, z80_addr[0]);
        else z80_req_addr <= z80_wa;
      end else if (z80_ack) begin
        if (z80_req_addr == sdr_addr) z80_pend <= 1'b0;
        if (z80_rom_cs && z80_wa == sdr_addr) begin
          z80_ok <= 1'b1; z80_dout <= pick(sdr_data, z80_addr[0]);
        end else if (!z80_rom_cs) z80_ok <= 1'b0;
      end else if (!z80_rom_cs) z80_ok <= 1'b0;
    end
  end

  // The sample port has no select to hold on to, so its byte lane is latched with the request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp_pend <= 1'b0; smp_req_addr <= '0; smp_sel <= 1'b0;
      smp_cv <= 1'b0; smp_ca <= '0; smp_cd <= '0; smp_ok <= 1'b0; smp_dout <= '0;
    end else begin
      smp_ok <= 1'b0;
      if (smp_ack) begin
        smp_cv <= 1'b1; smp_ca <= sdr_addr; smp_cd <= sdr_data;
      end
      if (smp_rd) begin
        smp_pend <= !smp_hit;
        if (smp_hit) begin
          smp_ok <= 1'b1; smp_dout <= pick(smp_hd, smp_addr[0]);
        end else begin
          smp_req_addr <= smp_wa; smp_sel <= smp_addr[0];
        end
      end else if (smp_ack && smp_pend && smp_req_addr == sdr_addr) begin
        smp_pend <= 1'b0;
        smp_ok   <= 1'b1;
        smp_dout <= pick(sdr_data, smp_sel);
      end
    end
  end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Bench for rom_fetch_arbiter: directed vector table, hand-written corner sequences and a
// randomized three-requester run against an SDRAM/cache model.
module tb_rom_fetch_arbiter;

  localparam logic [21:0] M68K_B = 22'h000000;
  localparam logic [21:0] Z80_B  = 22'h020000;
  localparam logic [21:0] SMP_B  = 22'h028000;

  logic        clk, reset_n;
  logic        m68k_rom_cs, z80_rom_cs, smp_rd, sdr_ack;
  logic [16:0] m68k_a, smp_addr;
  logic [15:0] z80_addr, sdr_data, m68k_dout;
  logic [7:0]  z80_dout, smp_dout;
  logic        m68k_ok, z80_ok, smp_ok, sdr_req;
  logic [21:0] sdr_addr;

  int total = 0;
  int bad = 0;
  logic auto_ack = 1'b0;
  logic mon_en = 1'b0;
  logic [21:0] want [3];
  logic        mc_valid [3];
  logic [21:0] mc_addr [3];
  logic [15:0] mc_data [3];

  typedef struct {
    logic [1:0]  port;
    logic [16:0] addr;
    logic [15:0] data;
    logic [21:0] exp_sdr;
    logic [15:0] exp_dout;
  } vec_t;
  vec_t vecs [8];

  rom_fetch_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m68k_rom_cs(m68k_rom_cs), .m68k_a(m68k_a), .m68k_dout(m68k_dout), .m68k_ok(m68k_ok),
    .z80_rom_cs(z80_rom_cs), .z80_addr(z80_addr), .z80_dout(z80_dout), .z80_ok(z80_ok),
    .smp_rd(smp_rd), .smp_addr(smp_addr), .smp_dout(smp_dout), .smp_ok(smp_ok),
    .sdr_req(sdr_req), .sdr_addr(sdr_addr), .sdr_ack(sdr_ack), .sdr_data(sdr_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m68k_rom_cs = 1'b0; z80_rom_cs = 1'b0; smp_rd = 1'b0; sdr_ack = 1'b0; sdr_data = '0;
    m68k_a = '0; z80_addr = '0; smp_addr = '0;
    for (int i = 0; i < 3; i++) mc_valid[i] = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  // ---------------- model helpers ----------------
  function automatic logic [15:0] mem_word(input logic [21:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd2654435761;
    return t[31:16] ^ 16'(a);
  endfunction

  function automatic logic [7:0] pick(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

  function automatic int port_of(input logic [21:0] a);
    if (a < Z80_B) return 0;
    if (a < SMP_B) return 1;
    return 2;
  endfunction

  function automatic logic port_ok(input logic [1:0] p);
    case (p)
      2'd0:    return m68k_ok;
      2'd1:    return z80_ok;
      default: return smp_ok;
    endcase
  endfunction

  function automatic logic [15:0] port_dout(input logic [1:0] p);
    case (p)
      2'd0:    return m68k_dout;
      2'd1:    return {8'd0, z80_dout};
      default: return {8'd0, smp_dout};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_lat(input string name, input logic hit, input int cnt);
    if (hit) check({name, "_hit_lat"}, 32'(cnt), 32'd1);
    else check({name, "_miss_lat"}, 32'(cnt >= 3 && cnt < 40), 32'd1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_req();
    int cnt = 0;
    while (!sdr_req && cnt < 10) begin
      tick();
      cnt++;
    end
    check("sdr_req_seen", 32'(sdr_req), 32'd1);
  endtask

  task automatic ack_now(input logic [15:0] d);
    sdr_data = d;
    sdr_ack  = 1'b1;
    tick();
    sdr_ack  = 1'b0;
  endtask

  // SDRAM responder for the randomized run: random 0..3 extra cycles before each ack.
  initial begin
    int lat = 0;
    forever begin
      tick();
      if (sdr_ack) sdr_ack = 1'b0;
      else if (auto_ack && sdr_req) begin
        if (lat == 0) begin
          sdr_data = mem_word(sdr_addr);
          sdr_ack  = 1'b1;
          lat = $urandom_range(0, 3);
        end else lat--;
      end
    end
  end

  // Bus monitor: each completed read must be the word its requester asked for, and it fills
  // that requester's modelled cache.
  initial begin
    logic prev_req = 1'b0, prev_ack = 1'b0;
    logic [21:0] prev_addr = '0;
    int p;
    forever begin
      @(negedge clk);
      if (mon_en && sdr_req && prev_req && !prev_ack)
        check("sdr_addr_stable", 32'(sdr_addr), 32'(prev_addr));
      if (mon_en && sdr_req && sdr_ack) begin
        p = port_of(sdr_addr);
        check("grant_want", 32'(sdr_addr), 32'(want[p]));
        mc_valid[p] = 1'b1;
        mc_addr[p]  = sdr_addr;
        mc_data[p]  = sdr_data;
      end
      prev_req = sdr_req; prev_ack = sdr_ack; prev_addr = sdr_addr;
    end
  end

  // ---------------- random agents ----------------
  task automatic m68k_agent(input int n);
    logic [16:0] a; logic [21:0] wa; logic hit; int cnt;
    for (int i = 0; i < n; i++) begin
      a   = 17'($urandom_range(0, 5)) << 4;
      wa  = M68K_B + {5'd0, a};
      hit = mc_valid[0] && mc_addr[0] == wa;
      want[0] = wa;
      m68k_a = a; m68k_rom_cs = 1'b1;
      cnt = 0;
      do begin tick(); cnt++; end while (!m68k_ok && cnt < 40);
      check_lat("m68k", hit, cnt);
      check("m68k_rand_dout", 32'(m68k_dout), 32'(mem_word(wa)));
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("m68k_ok_hold", 32'(m68k_ok), 32'd1);
      end
      m68k_rom_cs = 1'b0;
      tick();
      check("m68k_ok_clear", 32'(m68k_ok), 32'd0);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic z80_agent(input int n);
    logic [15:0] a; logic [21:0] wa; logic hit, held; int cnt;
    held = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = 16'h0100 + 16'($urandom_range(0, 11));
      if (held && a == z80_addr) a = a ^ 16'h0001;
      wa  = Z80_B + {7'd0, a[15:1]};
      hit = mc_valid[1] && mc_addr[1] == wa;
      want[1] = wa;
      z80_addr = a; z80_rom_cs = 1'b1;
      cnt = 0;
      do begin tick(); cnt++; end while (!z80_ok && cnt < 40);
      check_lat("z80", hit, cnt);
      check("z80_rand_dout", 32'(z80_dout), 32'(pick(mem_word(wa), a[0])));
      held = ($urandom_range(0, 1) == 1);
      if (!held) begin
        z80_rom_cs = 1'b0;
        tick();
        check("z80_ok_clear", 32'(z80_ok), 32'd0);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    z80_rom_cs = 1'b0;
    tick();
  endtask

  task automatic smp_agent(input int n);
    logic [16:0] a; logic [21:0] wa; logic hit; int cnt;
    for (int i = 0; i < n; i++) begin
      a   = 17'h00400 + 17'($urandom_range(0, 9));
      wa  = SMP_B + {6'd0, a[16:1]};
      hit = mc_valid[2] && mc_addr[2] == wa;
      want[2] = wa;
      smp_addr = a; smp_rd = 1'b1;
      cnt = 0;
      do begin tick(); smp_rd = 1'b0; cnt++; end while (!smp_ok && cnt < 40);
      check_lat("smp", hit, cnt);
      check("smp_rand_dout", 32'(smp_dout), 32'(pick(mem_word(wa), a[0])));
      tick();
      check("smp_ok_pulse", 32'(smp_ok), 32'd0);
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [21:0] rr_exp [3];

    vecs[0] = '{2'd0, 17'h00010, 16'h4E71, 22'h000010, 16'h4E71};
    vecs[1] = '{2'd1, 17'h00123, 16'hA55A, 22'h020091, 16'h00A5};
    vecs[2] = '{2'd2, 17'h00005, 16'h1234, 22'h028002, 16'h0012};
    vecs[3] = '{2'd0, 17'h1FFFF, 16'hBEEF, 22'h01FFFF, 16'hBEEF};
    vecs[4] = '{2'd1, 17'h0EFFE, 16'h7788, 22'h0277FF, 16'h0088};
    vecs[5] = '{2'd2, 17'h1FFFF, 16'hCAFE, 22'h037FFF, 16'h00CA};
    vecs[6] = '{2'd1, 17'h00000, 16'h0102, 22'h020000, 16'h0002};
    vecs[7] = '{2'd2, 17'h00000, 16'h5566, 22'h028000, 16'h0066};

    // Reset state, checked while reset is held.
    reset_n = 1'b0;
    m68k_rom_cs = 1'b0; z80_rom_cs = 1'b0; smp_rd = 1'b0; sdr_ack = 1'b0; sdr_data = '0;
    m68k_a = '0; z80_addr = '0; smp_addr = '0;
    repeat (2) tick();
    check("rst_sdr_req", 32'(sdr_req), 32'd0);
    check("rst_sdr_addr", 32'(sdr_addr), 32'd0);
    check("rst_m68k_ok", 32'(m68k_ok), 32'd0);
    check("rst_z80_ok", 32'(z80_ok), 32'd0);
    check("rst_smp_ok", 32'(smp_ok), 32'd0);
    check("rst_m68k_dout", 32'(m68k_dout), 32'd0);
    check("rst_z80_dout", 32'(z80_dout), 32'd0);
    check("rst_smp_dout", 32'(smp_dout), 32'd0);
    do_reset();

    // Directed vectors: address mapping, byte lanes and ok behaviour per port.
    for (int i = 0; i < 8; i++) begin
      case (vecs[i].port)
        2'd0: begin m68k_a = vecs[i].addr; m68k_rom_cs = 1'b1; end
        2'd1: begin z80_addr = vecs[i].addr[15:0]; z80_rom_cs = 1'b1; end
        default: begin smp_addr = vecs[i].addr; smp_rd = 1'b1; end
      endcase
      tick();
      smp_rd = 1'b0;
      wait_req();
      check("vec_sdr_addr", 32'(sdr_addr), 32'(vecs[i].exp_sdr));
      repeat (2) tick();
      check("vec_req_held", 32'(sdr_req), 32'd1);
      check("vec_ok_before_ack", 32'(port_ok(vecs[i].port)), 32'd0);
      ack_now(vecs[i].data);
      check("vec_ok", 32'(port_ok(vecs[i].port)), 32'd1);
      check("vec_dout", 32'(port_dout(vecs[i].port)), 32'(vecs[i].exp_dout));
      check("vec_req_drop", 32'(sdr_req), 32'd0);
      tick();
      check("vec_ok_next", 32'(port_ok(vecs[i].port)), 32'(vecs[i].port != 2'd2));
      if (vecs[i].port != 2'd2) begin
        m68k_rom_cs = 1'b0; z80_rom_cs = 1'b0;
        tick();
        check("vec_ok_cs_drop", 32'(port_ok(vecs[i].port)), 32'd0);
      end
    end

    // Z80 byte pair in one word: second read is a cache hit.
    do_reset();
    z80_addr = 16'h0123; z80_rom_cs = 1'b1;
    tick();
    wait_req();
    check("z80_pair_addr", 32'(sdr_addr), 32'h020091);
    tick();
    ack_now(16'hBEAD);
    check("z80_pair_ok1", 32'(z80_ok), 32'd1);
    check("z80_pair_hi", 32'(z80_dout), 32'hBE);
    z80_addr = 16'h0122;
    tick();
    check("z80_pair_ok2", 32'(z80_ok), 32'd1);
    check("z80_pair_lo", 32'(z80_dout), 32'hAD);
    check("z80_pair_no_req", 32'(sdr_req), 32'd0);
    repeat (3) tick();
    check("z80_pair_no_req_later", 32'(sdr_req), 32'd0);
    z80_rom_cs = 1'b0;
    tick();

    // All three pending together: strict round-robin, one idle cycle between reads.
    do_reset();
    rr_exp[0] = 22'h000100; rr_exp[1] = 22'h020100; rr_exp[2] = 22'h028180;
    m68k_a = 17'h00100; m68k_rom_cs = 1'b1;
    z80_addr = 16'h0200; z80_rom_cs = 1'b1;
    smp_addr = 17'h00300; smp_rd = 1'b1;
    tick();
    smp_rd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_req();
      check("rr_addr", 32'(sdr_addr), 32'(rr_exp[k]));
      ack_now(16'h1000 + 16'(k));
      check("rr_req_gap", 32'(sdr_req), 32'd0);
      if (k < 2) begin
        tick();
        check("rr_turnaround", 32'(sdr_req), 32'd1);
      end
    end
    check("rr_smp_ok", 32'(smp_ok), 32'd1);
    check("rr_smp_dout", 32'(smp_dout), 32'h02);
    check("rr_m68k_dout", 32'(m68k_dout), 32'h1000);
    check("rr_z80_dout", 32'(z80_dout), 32'h01);
    m68k_rom_cs = 1'b0; z80_rom_cs = 1'b0;
    tick();
    m68k_a = 17'h00104; m68k_rom_cs = 1'b1;
    z80_addr = 16'h0204; z80_rom_cs = 1'b1;
    tick();
    wait_req();
    check("rr_ptr_wrap_m68k", 32'(sdr_addr), 32'h000104);
    ack_now(16'h2000);
    wait_req();
    check("rr_ptr_wrap_z80", 32'(sdr_addr), 32'h020102);
    ack_now(16'h2001);
    m68k_rom_cs = 1'b0; z80_rom_cs = 1'b0;
    tick();

    // 68000 select drops while its read is outstanding.
    do_reset();
    m68k_a = 17'h00200; m68k_rom_cs = 1'b1;
    tick();
    wait_req();
    m68k_rom_cs = 1'b0;
    tick();
    ack_now(16'hC0DE);
    check("abort_ok_ack", 32'(m68k_ok), 32'd0);
    tick();
    check("abort_ok_after", 32'(m68k_ok), 32'd0);
    m68k_rom_cs = 1'b1;
    tick();
    check("abort_reread_ok", 32'(m68k_ok), 32'd1);
    check("abort_reread_dout", 32'(m68k_dout), 32'hC0DE);
    check("abort_reread_no_req", 32'(sdr_req), 32'd0);
    tick();
    check("abort_reread_no_req_later", 32'(sdr_req), 32'd0);
    m68k_rom_cs = 1'b0;
    tick();

    // Reset while a read is outstanding; the late ack must be ignored.
    do_reset();
    m68k_a = 17'h00300; m68k_rom_cs = 1'b1;
    tick();
    wait_req();
    tick();
    reset_n = 1'b0; m68k_rom_cs = 1'b0;
    #1;
    check("rstwait_req", 32'(sdr_req), 32'd0);
    check("rstwait_m68k_ok", 32'(m68k_ok), 32'd0);
    check("rstwait_z80_ok", 32'(z80_ok), 32'd0);
    check("rstwait_smp_ok", 32'(smp_ok), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    ack_now(16'hDEAD);
    check("late_ack_req", 32'(sdr_req), 32'd0);
    check("late_ack_ok", 32'(m68k_ok), 32'd0);
    m68k_rom_cs = 1'b1;
    tick();
    check("late_ack_not_cached", 32'(m68k_ok), 32'd0);
    wait_req();
    check("late_ack_refetch_addr", 32'(sdr_addr), 32'h000300);
    ack_now(16'h1111);
    check("late_ack_refetch_dout", 32'(m68k_dout), 32'h1111);
    m68k_rom_cs = 1'b0;
    tick();

    // Randomized concurrent traffic from all three requesters.
    do_reset();
    mon_en = 1'b1;
    auto_ack = 1'b1;
    fork
      m68k_agent(25);
      z80_agent(25);
      smp_agent(25);
    join
    auto_ack = 1'b0;
    repeat (4) tick();
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog expired actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
